apb_lbus_bridge: RTL and testbench
==================================

Name: apb_lbus_bridge

Overview:
APB3 completer that converts APB transfers into the single-cycle local register bus (en/we/addr/wdata/rdata). The downstream register slave has 1-cycle registered read latency. Sits directly upstream of the CSR register bank and drives its local-bus inputs. Address windowing, alignment checking, and error signalling are done here, so an illegal access never reaches the slave.

Parameters:
p_BASE_ADDR, 'hF00, byte base of the decoded window; must be aligned to p_WIN_BYTES.
p_WIN_BYTES, 32, window size in bytes; power of two; 8 words by default.
p_EXTRA_WAIT, 0, additional pready wait states inserted before every response (0..15).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  APB direction, 1 = write
paddr  input  12  APB byte address
pwdata  input  32  APB write data
pready  output  1  APB ready
prdata  output  32  APB read data
pslverr  output  1  APB error, valid when pready=1
en  output  1  local-bus strobe, one cycle per accepted access
we  output  1  local-bus write enable, qualified by en
addr  output  12  local-bus byte address (the latched paddr)
wdata  output  32  local-bus write data (the latched pwdata)
rdata  input  32  local-bus read data, valid the cycle after en with we=0
err_cnt  output  8  saturating count of pslverr responses

Behaviour:
- Reset (async, rst_n=0): state=IDLE; wait counter=0.
  - All outputs are 0: pready, pslverr, prdata, en, we, addr, wdata, err_cnt.
  - Reset mid-transfer aborts the transfer, with no en issued afterwards.
- All outputs are registered.
- FSM states: IDLE, ISSUE, CAPT, WAIT, RESP.
- IDLE:
  - On psel=1 && penable=0 (setup phase), latch paddr, pwrite and pwdata.
  - Decode error when paddr[1:0]!=0, paddr<p_BASE_ADDR, or paddr>=p_BASE_ADDR+p_WIN_BYTES.
  - No error -> ISSUE.
  - Error -> WAIT, or RESP directly if p_EXTRA_WAIT=0; the error flag is set and en is never asserted.
  - psel=1 && penable=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- ISSUE: en=1, we=latched pwrite, addr and wdata driven from the latches, for exactly one cycle.
  - Write -> WAIT/RESP.
  - Read -> CAPT.
- CAPT: en=0; prdata<=rdata (the slave's registered value); -> WAIT/RESP.
- WAIT: counter loads p_EXTRA_WAIT-1 on entry and decrements each cycle; at 0 -> RESP.
- RESP: pready=1; pslverr=error flag.
  - On an error read, prdata=0. On an error write, nothing is written.
  - On psel&&penable: the transfer completes; next state is IDLE; pready and pslverr drop in the following cycle.
  - If penable=0 in RESP, hold RESP.
- Latency with p_EXTRA_WAIT=0, counting the setup cycle as T0:
  - Write: en at T1, pready at T2 (1 wait state).
  - Read: en at T1, rdata captured at T2, pready at T3 (2 wait states).
  - Error access: pready at T1 (0 wait states).
- Abort: psel=0 in any non-IDLE state -> IDLE at the next edge.
  - en is not issued if the state was not yet ISSUE.
  - prdata holds its value; err_cnt is not incremented.
- Back-to-back: a new setup phase is accepted in the cycle after RESP completes. At most one en per APB transfer; en never occurs on consecutive cycles.
- prdata holds its last value between reads; writes do not change it.
- err_cnt increments on completion of each RESP with pslverr=1 and saturates at 8'hFF.
- addr, wdata and we hold their last values when en=0.

Test Plan:
- Write 'hF08 data 'hDEADBEEF -> en=1, we=1, addr='hF08, wdata='hDEADBEEF exactly one cycle at T1; pready=1, pslverr=0 at T2.
- Read 'hF08 after that write, with the slave returning 'hDEADBEEF -> en=1, we=0 at T1; pready=1 at T3 with prdata='hDEADBEEF.
- Read 'hF20 (out of window), then write 'hF02 (misaligned) -> no en; each gives pready=1, pslverr=1 at T1; read prdata=0; err_cnt=2.
- p_EXTRA_WAIT=3, write 'hF1C -> pready first high at T5; en still only at T1.
- 256 consecutive error transfers -> err_cnt saturates at 'hFF.
- Deassert psel during ISSUE, then deassert rst_n during a read CAPT -> FSM returns to IDLE with no further en.
  - After the abort: err_cnt and prdata unchanged.
  - After the reset: all outputs 0 immediately.
  - A following write to 'hF00 completes normally.

Source files
------------

// File: rtl/apb_lbus_bridge_if.sv
// APB3 + local register bus bundle for apb_lbus_bridge.
// slave modport = bridge side, master modport = APB requester and register slave side.
//
// Signals:
//   psel, penable, pwrite, paddr[11:0], pwdata[31:0] : APB request
//   pready, prdata[31:0], pslverr                    : APB response
//   en, we, addr[11:0], wdata[31:0]                  : local-bus strobe/command
//   rdata[31:0]                                      : local-bus read data (1-cycle latency)
//   err_cnt[7:0]                                     : saturating pslverr count
interface apb_lbus_bridge_if;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        en;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  err_cnt;

    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        input  rdata,
        output pready,
        output prdata,
        output pslverr,
        output en,
        output we,
        output addr,
        output wdata,
        output err_cnt
    );

    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        output rdata,
        input  pready,
        input  prdata,
        input  pslverr,
        input  en,
        input  we,
        input  addr,
        input  wdata,
        input  err_cnt
    );

endinterface

// File: rtl/apb_lbus_bridge.sv
// APB3 completer driving a single-cycle local register bus, with window/alignment
// decode, optional extra wait states, error response and a saturating error counter.
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : apb_lbus_bridge_if.slave (APB request/response, local bus, err_cnt)
module apb_lbus_bridge #(
    parameter int p_BASE_ADDR  = 'hF00,
    parameter int p_WIN_BYTES  = 32,
    parameter int p_EXTRA_WAIT = 0
) (
    input logic              clk,
    input logic              rst_n,
    apb_lbus_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPT,
        WAIT,
        RESP
    } state_t;

    localparam logic [12:0] c_LO = 13'(p_BASE_ADDR);
    localparam logic [12:0] c_HI = 13'(p_BASE_ADDR + p_WIN_BYTES);
    localparam bit          c_NO_WAIT = (p_EXTRA_WAIT == 0);
    localparam int          c_WI = (p_EXTRA_WAIT > 0) ? p_EXTRA_WAIT - 1 : 0;
    localparam logic [3:0]  c_WAIT_INIT = 4'(c_WI);

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_wr;
    logic        err_q;

    logic        pready_q;
    logic        pslverr_q;
    logic [31:0] prdata_q;
    logic        en_q;
    logic        we_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  err_cnt_q;

    logic        setup;
    logic        dec_err;
    logic        fin;
    logic        to_resp;
    logic        rsp_err;
    logic        rsp_rd;

    assign setup = bus.psel && !bus.penable;

    assign dec_err = (bus.paddr[1:0] != 2'b00)
                  || ({1'b0, bus.paddr} < c_LO)
                  || ({1'b0, bus.paddr} >= c_HI);

    // fin: the data part of the transfer is done this cycle, so the
    // response (directly, or via the wait counter) starts at the edge.
    always_comb begin
        fin     = 1'b0;
        rsp_err = err_q;
        rsp_rd  = !lat_wr;
        unique case (state)
            IDLE: begin
                fin     = setup && dec_err;
                rsp_err = 1'b1;
                rsp_rd  = !bus.pwrite;
            end
            ISSUE:   fin = bus.psel && lat_wr;
            CAPT:    fin = bus.psel;
            WAIT:    fin = bus.psel && (cnt == 4'd0);
            default: fin = 1'b0;
        endcase
        to_resp = fin && (c_NO_WAIT || state == WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_wr    <= 1'b0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    en_q <= 1'b0;
                    if (setup) begin
                        lat_wr <= bus.pwrite;
                        err_q  <= dec_err;
                        // Command is loaded straight into the bus
                        // registers so it is driven during ISSUE;
                        // erroneous accesses leave them untouched.
                        if (!dec_err) begin
                            state   <= ISSUE;
                            en_q    <= 1'b1;
                            we_q    <= bus.pwrite;
                            addr_q  <= bus.paddr;
                            wdata_q <= bus.pwdata;
                        end
                    end
                end
                ISSUE: begin
                    en_q <= 1'b0;
                    if (!bus.psel) begin
                        state <= IDLE;
                    end else if (!lat_wr) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    if (!bus.psel) begin
                        state <= IDLE;
                    end else begin
                        prdata_q <= bus.rdata;
                    end
                end
                WAIT: begin
                    if (!bus.psel) begin
                        state <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!bus.psel || bus.penable) begin
                        state     <= IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        if (bus.psel && pslverr_q
                            && err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (fin) begin
                if (to_resp) begin
                    state     <= RESP;
                    pready_q  <= 1'b1;
                    pslverr_q <= rsp_err;
                    if (rsp_err && rsp_rd) begin
                        prdata_q <= '0;
                    end
                end else begin
                    state <= WAIT;
                    cnt   <= c_WAIT_INIT;
                end
            end
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;
    assign bus.en      = en_q;
    assign bus.we      = we_q;
    assign bus.addr    = addr_q;
    assign bus.wdata   = wdata_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_lbus_bridge.sv
// Self-checking bench for apb_lbus_bridge: two instances (no extra wait / 3 waits),
// directed and random APB transfers against a behavioural model.
module tb_apb_lbus_bridge;

    logic clk;
    logic rst_n;
    bit   cur;

    logic        psel_d;
    logic        penable_d;
    logic        pwrite_d;
    logic [11:0] paddr_d;
    logic [31:0] pwdata_d;

    logic [31:0] rd0, rd1;
    logic [31:0] smem0 [8];
    logic [31:0] smem1 [8];

    logic        pready_s, pslverr_s, en_s, we_s;
    logic [31:0] prdata_s, wdata_s;
    logic [11:0] addr_s;
    logic [7:0]  err_cnt_s;

    logic [31:0] em [2][8];
    logic [31:0] exp_prd [2];
    logic [7:0]  exp_ec [2];

    int vecs;
    int errs;

    apb_lbus_bridge_if b0 ();
    apb_lbus_bridge_if b1 ();

    apb_lbus_bridge #(
        .p_BASE_ADDR (12'hF00),
        .p_WIN_BYTES (32),
        .p_EXTRA_WAIT(0)
    ) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b0.slave)
    );

    apb_lbus_bridge #(
        .p_BASE_ADDR (12'hF00),
        .p_WIN_BYTES (32),
        .p_EXTRA_WAIT(3)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b1.slave)
    );

    assign b0.psel    = psel_d & ~cur;
    assign b1.psel    = psel_d & cur;
    assign b0.penable = penable_d;
    assign b1.penable = penable_d;
    assign b0.pwrite  = pwrite_d;
    assign b1.pwrite  = pwrite_d;
    assign b0.paddr   = paddr_d;
    assign b1.paddr   = paddr_d;
    assign b0.pwdata  = pwdata_d;
    assign b1.pwdata  = pwdata_d;
    assign b0.rdata   = rd0;
    assign b1.rdata   = rd1;

    always_comb begin
        pready_s  = cur ? b1.pready  : b0.pready;
        pslverr_s = cur ? b1.pslverr : b0.pslverr;
        prdata_s  = cur ? b1.prdata  : b0.prdata;
        en_s      = cur ? b1.en      : b0.en;
        we_s      = cur ? b1.we      : b0.we;
        addr_s    = cur ? b1.addr    : b0.addr;
        wdata_s   = cur ? b1.wdata   : b0.wdata;
        err_cnt_s = cur ? b1.err_cnt : b0.err_cnt;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register slave: registered read data, writes on en&we.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                smem0[i] <= '0;
                smem1[i] <= '0;
            end
        end else begin
            if (b0.en) begin
                if (b0.we) smem0[b0.addr[4:2]] <= b0.wdata;
                else       rd0 <= smem0[b0.addr[4:2]];
            end
            if (b1.en) begin
                if (b1.we) smem1[b1.addr[4:2]] <= b1.wdata;
                else       rd1 <= smem1[b1.addr[4:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input bit s, input bit wr, input logic [11:0] a,
                        input logic [31:0] d);
        bit         bad;
        int         lat;
        int         k;
        int         en_n;
        int         en_at;
        logic [2:0] ix;
        bad = (a[1:0] != 2'b00) || (a < 12'hF00) || (a >= 12'hF20);
        lat = (s ? 3 : 0) + (bad ? 1 : (wr ? 2 : 3));
        ix  = a[4:2];
        cur = s;
        @(posedge clk); #1;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = wr;
        paddr_d   = a;
        pwdata_d  = d;
        @(posedge clk); #1;
        penable_d = 1'b1;
        k     = 1;
        en_n  = 0;
        en_at = 0;
        forever begin
            @(negedge clk);
            if (en_s) begin
                en_n++;
                en_at = k;
                check("bus_we", 32'(we_s), 32'(wr));
                check("bus_addr", 32'(addr_s), 32'(a));
                check("bus_wdata", wdata_s, d);
            end
            if (pready_s) break;
            if (k >= 40) begin
                check("pready_timeout", 32'(pready_s), 32'd1);
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        check("latency", 32'(k), 32'(lat));
        check("pslverr", 32'(pslverr_s), 32'(bad));
        if (!wr) exp_prd[s] = bad ? 32'd0 : em[s][ix];
        check("prdata", prdata_s, exp_prd[s]);
        if (!bad && wr) em[s][ix] = d;
        if (bad && exp_ec[s] != 8'hFF) exp_ec[s] = exp_ec[s] + 8'd1;
        check("en_count", 32'(en_n), bad ? 32'd0 : 32'd1);
        if (!bad) check("en_cycle", 32'(en_at), 32'd1);
        @(posedge clk); #1;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        @(negedge clk);
        check("pready_drop", 32'(pready_s), 32'd0);
        check("pslverr_drop", 32'(pslverr_s), 32'd0);
        check("en_idle", 32'(en_s), 32'd0);
        check("err_cnt", 32'(err_cnt_s), 32'(exp_ec[s]));
    endtask

    task automatic rand_xfer(input bit s);
        int          kind;
        logic [11:0] a;
        kind = $urandom_range(0, 3);
        if (kind <= 1) begin
            a = 12'hF00 + 12'($urandom_range(0, 7) * 4);
        end else if (kind == 2) begin
            a = 12'hF00 + 12'($urandom_range(0, 7) * 4)
              + 12'($urandom_range(1, 3));
        end else if ($urandom_range(0, 1) == 1) begin
            a = 12'($urandom_range(0, 'hEFF));
        end else begin
            a = 12'($urandom_range('hF20, 'hFFF));
        end
        xfer(s, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    task automatic check_reset_outputs(input bit s, input string tag);
        cur = s;
        #0;
        check({tag, "_pready"}, 32'(pready_s), 32'd0);
        check({tag, "_pslverr"}, 32'(pslverr_s), 32'd0);
        check({tag, "_prdata"}, prdata_s, 32'd0);
        check({tag, "_en"}, 32'(en_s), 32'd0);
        check({tag, "_we"}, 32'(we_s), 32'd0);
        check({tag, "_addr"}, 32'(addr_s), 32'd0);
        check({tag, "_wdata"}, wdata_s, 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt_s), 32'd0);
    endtask

    initial begin
        vecs      = 0;
        errs      = 0;
        cur       = 1'b0;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = '0;
        pwdata_d  = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) em[s][i] = '0;
            exp_prd[s] = '0;
            exp_ec[s]  = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs(1'b0, "rst0");
        check_reset_outputs(1'b1, "rst1");
        rst_n = 1'b1;

        // Directed: write then read back, then two error accesses.
        xfer(1'b0, 1'b1, 12'hF08, 32'hDEADBEEF);
        xfer(1'b0, 1'b0, 12'hF08, 32'h0);
        xfer(1'b0, 1'b0, 12'hF20, 32'h12345678);
        xfer(1'b0, 1'b1, 12'hF02, 32'h55AA55AA);
        check("err_cnt_two", 32'(b0.err_cnt), 32'd2);

        for (int i = 0; i < 40; i++) rand_xfer(1'b0);

        // Extra wait states.
        xfer(1'b1, 1'b1, 12'hF1C, 32'hCAFEF00D);
        xfer(1'b1, 1'b0, 12'hF1C, 32'h0);
        xfer(1'b1, 1'b0, 12'hF21, 32'h0);
        for (int i = 0; i < 12; i++) rand_xfer(1'b1);

        // Saturation of the error counter.
        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, 1'(i & 1), 12'hF01 + 12'((i % 8) * 4),
                 32'(i));
        end
        check("err_cnt_sat", 32'(b0.err_cnt), 32'hFF);

        // Abort during ISSUE of a read.
        cur = 1'b0;
        @(posedge clk); #1;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = 12'hF04;
        pwdata_d  = 32'h0BAD0BAD;
        @(posedge clk); #1;
        psel_d = 1'b0;
        @(negedge clk);
        check("abort_en_issued", 32'(en_s), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_en", 32'(en_s), 32'd0);
            check("abort_no_pready", 32'(pready_s), 32'd0);
        end
        check("abort_prdata", prdata_s, exp_prd[0]);
        check("abort_err_cnt", 32'(err_cnt_s), 32'(exp_ec[0]));

        // Reset while a read sits in CAPT.
        @(posedge clk); #1;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = 12'hF08;
        @(posedge clk); #1;
        penable_d = 1'b1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs(1'b0, "midrst");
        psel_d    = 1'b0;
        penable_d = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_prd[0] = '0;
        exp_ec[0]  = '0;
        for (int i = 0; i < 8; i++) em[0][i] = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_en", 32'(en_s), 32'd0);
        end
        xfer(1'b0, 1'b1, 12'hF00, 32'hA5A5F00D);
        xfer(1'b0, 1'b0, 12'hF00, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
